instruction_fetch: RTL and testbench

- Produces the instruction word and PC consumed by `instruction_decoder`, which sits on the other end of the instruction interface.
- Issues sequential word reads to instruction memory over a valid/ready request channel, accepts in-order read responses, and buffers them in a small FIFO.
- Presents instructions to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered words and discarding in-flight responses.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instruction_fetch.sv | 134 +++++++++++++
 tb/tb_instruction_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V front end.
// ifetch_state_e encodes the instruction_fetch FSM.
package riscv_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        FAULT = 2'd2
    } ifetch_state_e;

    localparam int InstrBytes = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instruction} entries with push, pop, flush and occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CntFull) || w_do_pop);

    // Pointer and occupancy bookkeeping; flush empties the buffer at once.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW + 1)'(w_do_push) - (AW + 1)'(w_do_pop);
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: sequential word reads, response buffering, redirect flush.
// Optional macro IFETCH_MISALIGN_CHK_EN: a misaligned redirect target raises a
// sticky o_fault after the flush; without it target bits[1:0] are cleared and
// the FAULT state is never entered.
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_arvalid,
    output logic [XLEN-1:0] o_imem_araddr,
    input  logic            i_imem_arready,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_imem_rready,
    output logic            o_instr_valid,
    output logic [31:0]     o_instruction,
    output logic [XLEN-1:0] o_instr_pc,
    input  logic            i_instr_ready,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_fault
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = XLEN + 32;
    localparam logic [CW:0] Credits = (CW + 1)'(FIFO_DEPTH);

    ifetch_state_e   r_state;
    logic            r_run;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic            r_fault;
    logic            r_fault_pend;

    logic [CW-1:0]   w_count;
    logic [FW-1:0]   w_head;
    logic            w_pop;
    logic            w_push;
    logic            w_ar_hs;
    logic            w_r_hs;
    logic [CW:0]     w_credit_used;
    logic [CW-1:0]   w_out_next;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_misalign;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign w_redir_pc = i_redirect_pc;
    assign w_misalign = |i_redirect_pc[1:0];
`else
    assign w_redir_pc = i_redirect_pc & ~XLEN'(3);
    assign w_misalign = 1'b0;
`endif

    // Credits count in-flight reads plus buffered words; a same-cycle pop frees
    // one, which keeps full throughput and still guarantees room for every response.
    assign w_credit_used  = {1'b0, r_outstanding} + {1'b0, w_count} - (CW + 1)'(w_pop);
    assign o_imem_arvalid = r_run && (r_state == FETCH) && (w_credit_used < Credits);
    assign o_imem_araddr  = {r_pc[XLEN-1:2], 2'b00};
    assign o_imem_rready  = r_run;

    assign w_ar_hs    = o_imem_arvalid && i_imem_arready;
    assign w_r_hs     = i_imem_rvalid && o_imem_rready;
    assign w_out_next = r_outstanding + CW'(w_ar_hs) - CW'(w_r_hs);

    // Responses are in request order, so the next response PC is a running
    // counter restarted at every redirect target.
    assign w_push = w_r_hs && (r_state == FETCH) && !i_redirect_valid;
    assign w_pop  = o_instr_valid && i_instr_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, i_imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (i_redirect_valid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign o_instr_valid = (w_count != '0) && (r_state != FAULT);
    assign o_instruction = o_instr_valid ? w_head[31:0] : 32'd0;
    assign o_instr_pc    = o_instr_valid ? w_head[FW-1:32] : '0;
    assign o_fault       = r_fault;

    // Fetch FSM with pc, outstanding-read, drop and fault bookkeeping; redirect wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= FETCH;
            r_run         <= 1'b0;
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_fault       <= 1'b0;
            r_fault_pend  <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_out_next;
            if (w_ar_hs) r_pc <= r_pc + XLEN'(InstrBytes);
            if (w_push)  r_rsp_pc <= r_rsp_pc + XLEN'(InstrBytes);

            if (i_redirect_valid) begin
                r_pc         <= w_redir_pc;
                r_rsp_pc     <= w_redir_pc;
                r_fault_pend <= w_misalign;
                r_drop_cnt   <= w_out_next;
                r_fault      <= 1'b0;
                if (w_out_next != '0) begin
                    r_state <= FLUSH;
                end else begin
                    r_state <= w_misalign ? FAULT : FETCH;
                    r_fault <= w_misalign;
                end
            end else if ((r_state == FLUSH) && w_r_hs) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
                if (r_drop_cnt == CW'(1)) begin
                    r_state <= r_fault_pend ? FAULT : FETCH;
                    r_fault <= r_fault_pend;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed table-driven bench for instruction_fetch with an in-order memory
// model that answers one cycle after each accepted request.
module tb_instruction_fetch;
    logic        i_clk;
    logic        i_rst_n;
    logic        o_imem_arvalid;
    logic [31:0] o_imem_araddr;
    logic        i_imem_arready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_imem_rready;
    logic        o_instr_valid;
    logic [31:0] o_instruction;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_fault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q[$];

    instruction_fetch dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .o_imem_arvalid   (o_imem_arvalid),
        .o_imem_araddr    (o_imem_araddr),
        .i_imem_arready   (i_imem_arready),
        .i_imem_rvalid    (i_imem_rvalid),
        .i_imem_rdata     (i_imem_rdata),
        .o_imem_rready    (o_imem_rready),
        .o_instr_valid    (o_instr_valid),
        .o_instruction    (o_instruction),
        .o_instr_pc       (o_instr_pc),
        .i_instr_ready    (i_instr_ready),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_fault          (o_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        bit          ar;
        bit          rdy;
        bit          mem;
        bit          rd;
        logic [31:0] rpc;
        bit          e_arv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vec [18];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[24:0], 7'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit ar, input bit rdy, input bit mem, input bit rd, input logic [31:0] rpc);
        i_imem_arready   = ar;
        i_instr_ready    = rdy;
        i_redirect_valid = rd;
        i_redirect_pc    = rpc;
        if (mem && q.size() > 0) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mdata(q[0]);
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = '0;
        end
        #1;
    endtask

    task automatic clk_edge();
        bit ar_hs;
        bit r_hs;
        logic [31:0] a;
        ar_hs = o_imem_arvalid && i_imem_arready;
        r_hs  = i_imem_rvalid && o_imem_rready;
        a     = o_imem_araddr;
        @(posedge i_clk);
        if (!i_rst_n) q.delete();
        else begin
            if (r_hs) void'(q.pop_front());
            if (ar_hs) q.push_back(a);
        end
        #1;
    endtask

    task automatic do_reset(input string tag);
        i_rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        clk_edge();
        clk_edge();
        chk({tag, " rst arvalid"}, 32'(o_imem_arvalid), 32'd0);
        chk({tag, " rst rready"}, 32'(o_imem_rready), 32'd0);
        chk({tag, " rst instr_valid"}, 32'(o_instr_valid), 32'd0);
        chk({tag, " rst fault"}, 32'(o_fault), 32'd0);
        chk({tag, " rst instruction"}, o_instruction, 32'd0);
        chk({tag, " rst instr_pc"}, o_instr_pc, 32'd0);
        i_rst_n = 1'b1;
        drive(0, 0, 0, 0, 32'h0);
        clk_edge();
    endtask

    task automatic chk_out(input string tag, input bit arv, input logic [31:0] addr,
                           input bit iv, input logic [31:0] pc);
        chk({tag, " arvalid"}, 32'(o_imem_arvalid), 32'(arv));
        if (arv) chk({tag, " araddr"}, o_imem_araddr, addr);
        chk({tag, " instr_valid"}, 32'(o_instr_valid), 32'(iv));
        if (iv) begin
            chk({tag, " instr_pc"}, o_instr_pc, pc);
            chk({tag, " instruction"}, o_instruction, mdata(pc));
        end
    endtask

    initial begin
        // ar rdy mem rd rpc | arv addr iv pc
        vec[0]  = '{1, 1, 1, 0, 32'h0,   1, 32'h00,  0, 32'h0};
        vec[1]  = '{1, 1, 1, 0, 32'h0,   1, 32'h04,  0, 32'h0};
        vec[2]  = '{1, 1, 1, 0, 32'h0,   1, 32'h08,  1, 32'h0};
        vec[3]  = '{1, 1, 1, 0, 32'h0,   1, 32'h0C,  1, 32'h4};
        vec[4]  = '{1, 0, 1, 0, 32'h0,   0, 32'h10,  1, 32'h8};
        vec[5]  = '{1, 0, 1, 0, 32'h0,   0, 32'h10,  1, 32'h8};
        vec[6]  = '{1, 0, 1, 0, 32'h0,   0, 32'h10,  1, 32'h8};
        vec[7]  = '{1, 1, 1, 0, 32'h0,   1, 32'h10,  1, 32'h8};
        vec[8]  = '{1, 0, 1, 0, 32'h0,   0, 32'h14,  1, 32'hC};
        vec[9]  = '{1, 0, 1, 0, 32'h0,   0, 32'h14,  1, 32'hC};
        vec[10] = '{1, 1, 0, 0, 32'h0,   1, 32'h14,  1, 32'hC};
        vec[11] = '{1, 1, 0, 0, 32'h0,   1, 32'h18,  1, 32'h10};
        vec[12] = '{1, 0, 0, 1, 32'h100, 0, 32'h1C,  0, 32'h0};
        vec[13] = '{1, 0, 1, 0, 32'h0,   0, 32'h100, 0, 32'h0};
        vec[14] = '{1, 0, 1, 0, 32'h0,   0, 32'h100, 0, 32'h0};
        vec[15] = '{1, 1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
        vec[16] = '{1, 1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
        vec[17] = '{1, 1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100};

        i_rst_n = 1'b0;
        do_reset("init");

        for (int i = 0; i < 18; i++) begin
            drive(vec[i].ar, vec[i].rdy, vec[i].mem, vec[i].rd, vec[i].rpc);
            chk_out($sformatf("row%0d", i), vec[i].e_arv, vec[i].e_addr, vec[i].e_iv, vec[i].e_pc);
            chk($sformatf("row%0d rready", i), 32'(o_imem_rready), 32'd1);
            clk_edge();
        end

        // Redirect together with a response and a request handshake, then a
        // second redirect while that stale request is being flushed.
        drive(1, 1, 1, 1, 32'h200);
        chk_out("h0", 1, 32'h10C, 1, 32'h104);
        clk_edge();
        drive(1, 1, 1, 1, 32'h300);
        chk_out("h1", 0, 32'h0, 0, 32'h0);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("h2", 1, 32'h300, 0, 32'h0);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("h3", 1, 32'h304, 0, 32'h0);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("h4", 1, 32'h308, 1, 32'h300);
        clk_edge();

        // PC wrap-around from the top of the address space.
        do_reset("wrap");
        drive(0, 0, 1, 1, 32'hFFFF_FFFC);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("w0", 1, 32'hFFFF_FFFC, 0, 32'h0);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("w1", 1, 32'h0, 0, 32'h0);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("w2", 1, 32'h4, 1, 32'hFFFF_FFFC);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("w3", 1, 32'h8, 1, 32'h0);
        clk_edge();

        // Misaligned redirect target.
        do_reset("mis");
        drive(0, 0, 1, 1, 32'h102);
        clk_edge();
`ifdef IFETCH_MISALIGN_CHK_EN
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 1, 0, 32'h0);
            chk($sformatf("m%0d fault", k), 32'(o_fault), 32'd1);
            chk_out($sformatf("m%0d", k), 0, 32'h0, 0, 32'h0);
            clk_edge();
        end
        drive(1, 1, 1, 1, 32'h200);
        chk("m2 fault", 32'(o_fault), 32'd1);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk("m3 fault", 32'(o_fault), 32'd0);
        chk_out("m3", 1, 32'h200, 0, 32'h0);
        clk_edge();
`else
        drive(1, 1, 1, 0, 32'h0);
        chk("m0 fault", 32'(o_fault), 32'd0);
        chk_out("m0", 1, 32'h100, 0, 32'h0);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("m1", 1, 32'h104, 0, 32'h0);
        clk_edge();
        drive(1, 1, 1, 0, 32'h0);
        chk_out("m2", 1, 32'h108, 1, 32'h100);
        clk_edge();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
